// File: rtl/bpu_pkg.sv
// Shared branch-prediction encodings and the 2-bit saturating counter update.
package bpu_pkg;

  localparam logic [1:0] BR_T_BRANCH = 2'b00;
  localparam logic [1:0] BR_T_JUMP   = 2'b01;
  localparam logic [1:0] BR_T_JR     = 2'b10;
  localparam logic [1:0] BR_T_NONE   = 2'b11;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] next;
    next = ctr;
    if (taken && ctr != CTR_ST) begin
      next = ctr + 2'd1;
    end else if (!taken && ctr != CTR_SNT) begin
      next = ctr - 2'd1;
    end
    return next;
  endfunction

endpackage

// File: rtl/bj_target_calc.sv
// Combinational resolved-target calculator for branch, j/jal and jr.
// Type BR_T_NONE yields the fall-through pc4.
module bj_target_calc
  import bpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [31:0]       instruction,
  input  logic [ADDR_W-1:0] pc4,
  input  logic [ADDR_W-1:0] rs_value,
  input  logic [1:0]        br_type,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] jump_target;
  logic              unused_opcode;

  assign unused_opcode = ^instruction[31:26];

  always_comb begin
    offset      = {{(ADDR_W-16){instruction[15]}}, instruction[15:0]} << 2;
    // Jump keeps the pc4 region above bit 27 and replaces the low 28 bits.
    jump_target        = pc4;
    jump_target[27:0]  = {instruction[25:0], 2'b00};
    case (br_type)
      BR_T_BRANCH: target = pc4 + offset;
      BR_T_JUMP:   target = jump_target;
      BR_T_JR:     target = rs_value;
      default:     target = pc4;
    endcase
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters; lookup and resolution both registered, latency 1, no backpressure.
// Optional lookup/hit statistics counters enabled by `define BTB_STATS_EN.
module branch_target_buffer
  import bpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              CLK,
  input  logic              reset_n,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              pred_valid,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic [31:0]       update_instruction,
  input  logic [ADDR_W-1:0] update_rs_value,
  input  logic [1:0]        update_type,
  input  logic              update_taken,
  output logic              resolved_valid,
  output logic [ADDR_W-1:0] resolved_target,
  output logic [31:0]       stat_lookups,
  output logic [31:0]       stat_hits
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  logic              ent_valid  [DEPTH];
  logic [TAG_W-1:0]  ent_tag    [DEPTH];
  logic [ADDR_W-1:0] ent_target [DEPTH];
  logic [1:0]        ent_type   [DEPTH];
  logic [1:0]        ent_ctr    [DEPTH];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, lk_taken;
  logic              up_hit, up_taken, up_write;
  logic [ADDR_W-1:0] up_pc4, up_target;
  logic              unused_pc_lsbs;

  assign unused_pc_lsbs = ^lookup_pc[1:0];

  assign lk_idx   = lookup_pc[IDX_W+1:2];
  assign lk_tag   = lookup_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit   = ent_valid[lk_idx] && (ent_tag[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && (ent_type[lk_idx] != BR_T_BRANCH || ent_ctr[lk_idx][1]);

  assign up_idx   = update_pc[IDX_W+1:2];
  assign up_tag   = update_pc[ADDR_W-1:IDX_W+2];
  assign up_hit   = ent_valid[up_idx] && (ent_tag[up_idx] == up_tag);
  assign up_pc4   = update_pc + ADDR_W'(4);
  // Jumps always redirect, so only branches carry a real outcome.
  assign up_taken = (update_type != BR_T_BRANCH) || update_taken;
  assign up_write = update_valid && (update_type != BR_T_NONE) && (up_hit || up_taken);

  bj_target_calc #(.ADDR_W(ADDR_W)) u_calc (
    .instruction (update_instruction),
    .pc4         (up_pc4),
    .rs_value    (update_rs_value),
    .br_type     (update_type),
    .target      (up_target)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      pred_valid      <= 1'b0;
      pred_hit        <= 1'b0;
      pred_taken      <= 1'b0;
      pred_target     <= '0;
      resolved_valid  <= 1'b0;
      resolved_target <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_valid[i]  <= 1'b0;
        ent_tag[i]    <= '0;
        ent_target[i] <= '0;
        ent_type[i]   <= BR_T_BRANCH;
        ent_ctr[i]    <= CTR_WNT;
      end
    end else begin
      // Reads use the table as it stood before this edge's write.
      pred_valid      <= lookup_valid;
      pred_hit        <= lookup_valid && lk_hit;
      pred_taken      <= lookup_valid && lk_taken;
      pred_target     <= (lookup_valid && lk_hit) ? ent_target[lk_idx] : '0;
      resolved_valid  <= update_valid;
      resolved_target <= update_valid ? up_target : '0;
      if (up_write) begin
        ent_valid[up_idx]  <= 1'b1;
        ent_tag[up_idx]    <= up_tag;
        ent_target[up_idx] <= up_target;
        ent_type[up_idx]   <= update_type;
        if (update_type == BR_T_BRANCH) begin
          ent_ctr[up_idx] <= up_hit ? ctr_update(ent_ctr[up_idx], update_taken) : CTR_WT;
        end else begin
          ent_ctr[up_idx] <= CTR_ST;
        end
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] lookups_q, hits_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      lookups_q <= '0;
      hits_q    <= '0;
    end else begin
      if (lookup_valid) begin
        lookups_q <= lookups_q + 32'd1;
      end
      if (lookup_valid && lk_hit) begin
        hits_q <= hits_q + 32'd1;
      end
    end
  end

  assign stat_lookups = lookups_q;
  assign stat_hits    = hits_q;
`else
  assign stat_lookups = 32'd0;
  assign stat_hits    = 32'd0;
`endif

endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised successor to the combinational branch/jump/jr target calculators.
- Direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters, giving the fetch stage a registered taken/target prediction.
- Computes the resolved target for branch, j/jal and jr internally from the resolving instruction, then trains the table.
- Sits between IF (lookup) and EX (update/resolution).

Parameters:
- ADDR_W, 32: PC/address width; must be >= 28.
- DEPTH, 16: number of BTB entries; power of two, >= 2.
- IDX_W (localparam) = log2(DEPTH).
- TAG_W (localparam) = ADDR_W-2-IDX_W.

Ports:
- CLK  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- lookup_valid  in  1  fetch requests a prediction this cycle.
- lookup_pc  in  ADDR_W  fetch PC.
- pred_valid  out  1  prediction outputs valid (one cycle after lookup_valid).
- pred_hit  out  1  tag match on a valid entry.
- pred_taken  out  1  predicted taken.
- pred_target  out  ADDR_W  predicted target; 0 when not hit.
- update_valid  in  1  a control instruction resolves this cycle.
- update_pc  in  ADDR_W  PC of the resolving instruction.
- update_instruction  in  32  raw instruction word.
- update_rs_value  in  ADDR_W  rs operand, used by jr.
- update_type  in  2  00 branch, 01 j/jal, 10 jr, 11 ignored.
- update_taken  in  1  actual outcome; forced to 1 internally for types 01 and 10.
- resolved_valid  out  1  one cycle after a valid update.
- resolved_target  out  ADDR_W  computed actual target.
- stat_lookups  out  32  see Optional Feature.
- stat_hits  out  32  see Optional Feature.

Behaviour:
- Reset (async, reset_n=0):
  - All entry valid bits cleared; all counters set to 2'b01.
  - All outputs are 0.
  - Any in-flight lookup or update is discarded; no write is performed.
- Addressing:
  - index = pc[IDX_W+1:2].
  - tag = pc[ADDR_W-1:IDX_W+2].
- Entry contents: valid, tag, target[ADDR_W-1:0], type[1:0], ctr[1:0].
- Lookup:
  - Registered, latency 1.
  - pred_valid = registered lookup_valid.
  - pred_hit = entry.valid && tag match.
  - pred_taken = pred_hit && (type != branch || ctr[1]).
  - pred_target = entry.target if pred_hit, else 0.
  - With lookup_valid=0, the next cycle has pred_valid=0 and the other pred_* outputs are 0.
- Target computation (pc4 = update_pc+4, modulo 2^ADDR_W):
  - Branch: pc4 + (sext(instr[15:0]) << 2), sign-extended to ADDR_W, wraps modulo 2^ADDR_W.
  - j/jal: {pc4[ADDR_W-1:28], instr[25:0], 2'b00}.
  - jr: update_rs_value.
  - Type 11: no table change; resolved_valid still asserts with resolved_target=pc4.
- Training (on a clock edge with update_valid=1):
  - Hit, branch: ctr increments if taken, decrements if not, saturating at 2'b11 / 2'b00. Target and type are rewritten.
  - Hit, j/jr: target rewritten; ctr forced to 2'b11.
  - Miss, taken: allocate (overwrite any victim). Set valid, tag, target, type; ctr = 2'b10 for branch, 2'b11 otherwise.
  - Miss, not-taken branch: no allocation.
- Resolution outputs: resolved_valid and resolved_target are registered, latency 1.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update contents (read-before-write). The update takes effect from the next cycle.
- No backpressure: both interfaces accept every cycle.

Optional Feature:
- Macro: BTB_STATS_EN.
- Defined:
  - stat_lookups increments on every lookup_valid.
  - stat_hits increments on every registered pred_hit.
  - Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: the counters are not instantiated; stat_lookups and stat_hits are tied to 0.

Decomposition:
- Shared package bpu_pkg:
  - Type encodings BR_T_BRANCH=2'b00, BR_T_JUMP=2'b01, BR_T_JR=2'b10, BR_T_NONE=2'b11.
  - Counter constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Counter saturating-update function.
- One sub-module, bj_target_calc: purely combinational, parametrised by ADDR_W. Inputs are instruction, pc4, rs_value and type; output is the target. Instantiated once on the update path.

Test Plan:
- Reset, then lookup_pc=0x00400000 -> next cycle pred_valid=1, pred_hit=0, pred_taken=0, pred_target=0; stats (if enabled) lookups=1, hits=0.
- Taken branch update: pc=0x00400010, instr imm=0xFFFE -> resolved_target=0x0040000C. Lookup of the same pc -> hit, taken, target 0x0040000C, ctr=10.
- Counter saturation on that branch:
  - Three more taken updates -> ctr=11.
  - Two not-taken updates -> ctr=01, pred_taken=0.
  - Two more not-taken -> ctr stays 00.
  - Target is still returned, with pred_taken=0.
- j at pc=0x10000000, instr[25:0]=0x0000100 -> target 0x10000400. Then jr at pc=0x10000040 (same index for DEPTH=16, different tag) with rs=0x00400020 -> evicts the entry; lookup of 0x10000000 now misses.
- Same-cycle lookup and update to one index -> lookup sees the old entry; a lookup the following cycle sees the new one. Not-taken branch miss -> no allocation.
- Assert reset_n mid-stream, with an update pending and a lookup in flight -> all outputs 0 immediately; after release, every previously trained pc misses.
